// File: rtl/mult_arbiter_pkg.sv
// Shared types and constants for the two-requester shift-add multiplier arbiter.
package mult_arbiter_pkg;

  localparam int L_WORD_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic req_id_t;

endpackage

// File: rtl/mult_arbiter_shift_add_dp.sv
// Shift-add multiplier datapath: multiplicand, multiplier and accumulator registers.
module mult_shift_add_dp
  import mult_arbiter_pkg::*;
#(
  parameter int L_word = L_WORD_DEFAULT
) (
  input  logic                  i_clk,
  input  logic                  i_clear,
  input  logic                  i_load,
  input  logic                  i_step,
  input  logic [L_word-1:0]     i_a,
  input  logic [L_word-1:0]     i_b,
  output logic                  o_multiplier_zero,
  output logic [2*L_word-1:0]   o_acc
);

  logic [2*L_word-1:0] r_mcand;
  logic [L_word-1:0]   r_mplier;
  logic [2*L_word-1:0] r_acc;

  always_ff @(posedge i_clk) begin
    if (i_clear) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
    end else if (i_load) begin
      r_mcand  <= {{L_word{1'b0}}, i_a};
      r_mplier <= i_b;
      r_acc    <= '0;
    end else if (i_step) begin
      if (r_mplier[0]) r_acc <= r_acc + r_mcand;
      r_mplier <= r_mplier >> 1;
      r_mcand  <= r_mcand << 1;
    end
  end

  // True when the step taken on this edge leaves the multiplier at zero.
  assign o_multiplier_zero = (r_mplier[L_word-1:1] == '0);
  assign o_acc             = r_acc;

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one shift-add multiplier between two requesters.
// Optional zero-operand bypass: define MULT_ARB_ZERO_BYPASS_EN.
module mult_arbiter
  import mult_arbiter_pkg::*;
#(
  parameter int L_word = L_WORD_DEFAULT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req0_valid,
  input  logic                  req1_valid,
  output logic                  req0_ready,
  output logic                  req1_ready,
  input  logic [L_word-1:0]     req0_a,
  input  logic [L_word-1:0]     req0_b,
  input  logic [L_word-1:0]     req1_a,
  input  logic [L_word-1:0]     req1_b,
  output logic                  resp0_valid,
  output logic                  resp1_valid,
  output logic [2*L_word-1:0]   resp0_product,
  output logic [2*L_word-1:0]   resp1_product,
  output logic                  busy
);

  localparam int CW = $clog2(L_word);
  localparam logic [CW-1:0] LAST_STEP = CW'(L_word - 1);

  state_t              r_state, w_next;
  logic                r_ptr;
  req_id_t             r_id;
  logic                r_b_zero;
  logic [CW-1:0]       r_cnt;
  logic                r_resp0_valid, r_resp1_valid;
  logic [2*L_word-1:0] r_resp0_product, r_resp1_product;

  req_id_t             w_sel;
  logic                w_any;
  logic [L_word-1:0]   w_a, w_b;
  logic                w_load, w_step, w_deliver, w_accept;
  logic                w_mplier_zero;
  logic [2*L_word-1:0] w_acc;

  // Handshake: reqN_ready is high only in IDLE, only for the arbitration winner,
  // and only while that requester is valid; a transfer happens on any edge
  // where reqN_valid && reqN_ready. A waiting requester must keep valid high.
  assign w_any = req0_valid | req1_valid;
  assign w_sel = (req0_valid && req1_valid) ? r_ptr : req1_valid;
  assign w_a   = w_sel ? req1_a : req0_a;
  assign w_b   = w_sel ? req1_b : req0_b;

`ifdef MULT_ARB_ZERO_BYPASS_EN
  logic w_operand_zero;
  assign w_operand_zero = (w_a == '0) || (w_b == '0);
`endif

  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_step     = 1'b0;
    w_deliver  = 1'b0;
    w_accept   = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!reset && w_any) begin
          req0_ready = ~w_sel;
          req1_ready = w_sel;
          w_accept   = 1'b1;
          w_load     = 1'b1;
`ifdef MULT_ARB_ZERO_BYPASS_EN
          w_next     = w_operand_zero ? DONE : MULT;
`else
          w_next     = MULT;
`endif
        end
      end
      MULT: begin
        w_step = 1'b1;
        // A zero multiplier runs the full word width instead of stopping early.
        if (r_b_zero ? (r_cnt == LAST_STEP) : w_mplier_zero) w_next = DONE;
      end
      DONE: begin
        w_deliver = 1'b1;
        w_next    = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state         <= IDLE;
      r_ptr           <= 1'b0;
      r_id            <= 1'b0;
      r_b_zero        <= 1'b0;
      r_cnt           <= '0;
      r_resp0_valid   <= 1'b0;
      r_resp1_valid   <= 1'b0;
      r_resp0_product <= '0;
      r_resp1_product <= '0;
    end else begin
      r_state       <= w_next;
      r_resp0_valid <= 1'b0;
      r_resp1_valid <= 1'b0;
      if (w_accept) begin
        r_id     <= w_sel;
        r_ptr    <= ~w_sel;
        r_b_zero <= (w_b == '0);
        r_cnt    <= '0;
      end else if (w_step) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_deliver) begin
        if (r_id) begin
          r_resp1_product <= w_acc;
          r_resp1_valid   <= 1'b1;
        end else begin
          r_resp0_product <= w_acc;
          r_resp0_valid   <= 1'b1;
        end
      end
    end
  end

  mult_shift_add_dp #(.L_word(L_word)) u_dp (
    .i_clk             (clock),
    .i_clear           (reset),
    .i_load            (w_load),
    .i_step            (w_step),
    .i_a               (w_a),
    .i_b               (w_b),
    .o_multiplier_zero (w_mplier_zero),
    .o_acc             (w_acc)
  );

  assign resp0_valid   = r_resp0_valid;
  assign resp1_valid   = r_resp1_valid;
  assign resp0_product = r_resp0_product;
  assign resp1_product = r_resp1_product;
  assign busy          = (r_state != IDLE) && !reset;

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: vector table, directed corner sequences, exhaustive and random traffic.
module tb_mult_arbiter;

  localparam int W  = 4;
  localparam int PW = 2 * W;

`ifdef MULT_ARB_ZERO_BYPASS_EN
  localparam int LAT_A_ZERO = 1;
  localparam int LAT_B_ZERO = 1;
`else
  localparam int LAT_A_ZERO = 4;
  localparam int LAT_B_ZERO = 5;
`endif

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic          v [2] = '{1'b0, 1'b0};
  logic [W-1:0]  a_in [2] = '{'0, '0};
  logic [W-1:0]  b_in [2] = '{'0, '0};
  logic          req0_ready, req1_ready, resp0_valid, resp1_valid, busy;
  logic [PW-1:0] resp0_product, resp1_product;

  mult_arbiter #(.L_word(W)) dut (
    .clock         (clock),
    .reset         (reset),
    .req0_valid    (v[0]),
    .req1_valid    (v[1]),
    .req0_ready    (req0_ready),
    .req1_ready    (req1_ready),
    .req0_a        (a_in[0]),
    .req0_b        (b_in[0]),
    .req1_a        (a_in[1]),
    .req1_b        (b_in[1]),
    .resp0_valid   (resp0_valid),
    .resp1_valid   (resp1_valid),
    .resp0_product (resp0_product),
    .resp1_product (resp1_product),
    .busy          (busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  // Edges from acceptance to the response pulse: steps until the multiplier is exhausted, plus one.
  function automatic int exp_latency(input logic [W-1:0] a, input logic [W-1:0] b);
    int k;
    k = 0;
`ifdef MULT_ARB_ZERO_BYPASS_EN
    if (a == 0 || b == 0) return 1;
`endif
    if (a == 0 && b == 0) return W + 1;
    if (b == 0) return W + 1;
    for (int i = 0; i < W; i++) if (b[i]) k = i + 1;
    return k + 1;
  endfunction

  logic [PW-1:0] exp_q[$];
  int            id_q[$];
  int            due_q[$];
  int            cyc = 0;
  bit            m_init = 1'b0;
  bit            m_free = 1'b1;
  int            m_ptr  = 0;
  logic [PW-1:0] m_prod [2] = '{'0, '0};
  int            acc_cnt [2] = '{0, 0};
  int            seen    [2] = '{0, 0};
  int            resp_cnt [2] = '{0, 0};
  int            accept_cyc [2] = '{0, 0};
  int            resp_cyc [2] = '{0, 0};
  logic [PW-1:0] last_prod [2] = '{'0, '0};
  int            grant_log[$];
  logic [2*W-1:0] op_q0[$];
  logic [2*W-1:0] op_q1[$];

  always @(posedge clock) cyc++;

  // Scoreboard: samples on the falling edge and predicts every output.
  always @(negedge clock) begin
    logic          rv [2];
    logic [PW-1:0] rp [2];
    int            w, did;
    bit            due_now;
    rv[0] = resp0_valid;   rv[1] = resp1_valid;
    rp[0] = resp0_product; rp[1] = resp1_product;
    if (m_init) begin
      due_now = (due_q.size() > 0) && (due_q[0] == cyc);
      did = due_now ? id_q[0] : -1;
      for (int n = 0; n < 2; n++)
        check($sformatf("resp%0d_valid@%0d", n, cyc), rv[n], (n == did));
      if (due_now) begin
        m_prod[did] = exp_q.pop_front();
        void'(id_q.pop_front());
        void'(due_q.pop_front());
        m_free = 1'b1;
      end
      for (int n = 0; n < 2; n++)
        check($sformatf("resp%0d_product@%0d", n, cyc), rp[n], m_prod[n]);
      w = (v[0] && v[1]) ? m_ptr : (v[1] ? 1 : 0);
      check($sformatf("req0_ready@%0d", cyc), req0_ready, m_free && !reset && v[0] && (w == 0));
      check($sformatf("req1_ready@%0d", cyc), req1_ready, m_free && !reset && v[1] && (w == 1));
      check($sformatf("busy@%0d", cyc), busy, !m_free && !reset);
      if (!reset && m_free && (v[0] || v[1])) begin
        exp_q.push_back(PW'(a_in[w]) * PW'(b_in[w]));
        due_q.push_back(cyc + 1 + exp_latency(a_in[w], b_in[w]));
        id_q.push_back(w);
        m_free = 1'b0;
        m_ptr  = (w == 0) ? 1 : 0;
        acc_cnt[w]++;
        accept_cyc[w] = cyc + 1;
        grant_log.push_back(w);
      end
      for (int n = 0; n < 2; n++)
        if (rv[n]) begin
          resp_cnt[n]++;
          resp_cyc[n]  = cyc;
          last_prod[n] = rp[n];
        end
    end
    if (reset) begin
      exp_q.delete();
      id_q.delete();
      due_q.delete();
      m_free = 1'b1;
      m_ptr  = 0;
      m_prod[0] = '0;
      m_prod[1] = '0;
      m_init = 1'b1;
    end
  end

  // ---------------- driver ----------------
  // Each requester holds valid until accepted, then loads its next queued operand pair.
  always @(posedge clock) begin
    #1;
    for (int n = 0; n < 2; n++) begin
      if (acc_cnt[n] != seen[n]) begin
        seen[n] = acc_cnt[n];
        v[n] = 1'b0;
      end
      if (!v[n]) begin
        if (n == 0 && op_q0.size() > 0) begin
          {a_in[0], b_in[0]} = op_q0.pop_front();
          v[0] = 1'b1;
        end else if (n == 1 && op_q1.size() > 0) begin
          {a_in[1], b_in[1]} = op_q1.pop_front();
          v[1] = 1'b1;
        end
      end
    end
  end

  task automatic push_op(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
    if (id == 0) op_q0.push_back({a, b});
    else op_q1.push_back({a, b});
  endtask

  task automatic wait_resp(input int id, input int rc, input string name);
    int t;
    t = 0;
    while (resp_cnt[id] == rc && t < 100) begin
      @(negedge clock);
      #1;
      t++;
    end
    check({name, "_responded"}, (resp_cnt[id] != rc), 1);
  endtask

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    while ((op_q0.size() > 0 || op_q1.size() > 0 || v[0] || v[1] || !m_free) && t < 3000) begin
      @(negedge clock);
      #1;
      t++;
    end
    check({name, "_drained"}, (t < 3000), 1);
  endtask

  task automatic pulse_reset(input int n);
    @(posedge clock);
    #2 reset = 1'b1;
    repeat (n) @(posedge clock);
    #2 reset = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int            id;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [PW-1:0] prod;
    int            lat;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int rc, ac, t, id;
    logic [W-1:0] ra, rb;
    logic [1:0]   m;

    vecs[0] = '{0, 4'd3,  4'd9,  8'd27,  5};
    vecs[1] = '{1, 4'd2,  4'd5,  8'd10,  4};
    vecs[2] = '{1, 4'd0,  4'd7,  8'd0,   LAT_A_ZERO};
    vecs[3] = '{0, 4'd5,  4'd0,  8'd0,   LAT_B_ZERO};
    vecs[4] = '{0, 4'd15, 4'd15, 8'd225, 5};
    vecs[5] = '{1, 4'd1,  4'd1,  8'd1,   2};
    vecs[6] = '{0, 4'd4,  4'd4,  8'd16,  4};
    vecs[7] = '{1, 4'd15, 4'd8,  8'd120, 5};
    vecs[8] = '{0, 4'd7,  4'd2,  8'd14,  3};

    repeat (3) @(posedge clock);
    #2 reset = 1'b0;
    @(negedge clock);
    #1;
    check("reset_resp0_product", resp0_product, 0);
    check("reset_resp1_product", resp1_product, 0);
    check("reset_busy", busy, 0);

    for (int i = 0; i < 9; i++) begin
      id = vecs[i].id;
      rc = resp_cnt[id];
      @(negedge clock);
      #2 push_op(id, vecs[i].a, vecs[i].b);
      wait_resp(id, rc, $sformatf("vec%0d", i));
      check($sformatf("vec%0d_product", i), last_prod[id], vecs[i].prod);
      check($sformatf("vec%0d_latency", i), resp_cyc[id] - accept_cyc[id], vecs[i].lat);
      wait_idle($sformatf("vec%0d", i));
    end

    // Simultaneous requests straight after reset: requester 0 wins first.
    pulse_reset(2);
    grant_log.delete();
    rc = resp_cnt[1];
    @(negedge clock);
    #2;
    push_op(0, 4'd15, 4'd15);
    push_op(1, 4'd2, 4'd5);
    wait_resp(1, rc, "simul");
    check("simul_grants", grant_log.size(), 2);
    if (grant_log.size() >= 2) begin
      check("simul_first", grant_log[0], 0);
      check("simul_second", grant_log[1], 1);
    end
    check("simul_prod0", last_prod[0], 225);
    check("simul_prod1", last_prod[1], 10);
    check("simul_lat0", resp_cyc[0] - accept_cyc[0], 5);
    check("simul_lat1", resp_cyc[1] - accept_cyc[1], 4);
    wait_idle("simul");

    // Fairness: both held valid for six operations.
    grant_log.delete();
    @(negedge clock);
    #2;
    for (int i = 0; i < 3; i++) begin
      push_op(0, W'($urandom_range(1, 15)), W'($urandom_range(1, 15)));
      push_op(1, W'($urandom_range(1, 15)), W'($urandom_range(1, 15)));
    end
    wait_idle("fair");
    check("fair_grants", grant_log.size(), 6);
    for (int i = 0; i < 6 && i < grant_log.size(); i++)
      check($sformatf("fair_grant%0d", i), grant_log[i], i % 2);

    // Reset during MULT aborts with no response.
    ac = acc_cnt[0];
    rc = resp_cnt[0];
    @(negedge clock);
    #2 push_op(0, 4'd5, 4'd8);
    t = 0;
    while (acc_cnt[0] == ac && t < 50) begin
      @(negedge clock);
      #1;
      t++;
    end
    check("abort_accepted", (acc_cnt[0] != ac), 1);
    @(posedge clock);
    @(posedge clock);
    #2 reset = 1'b1;
    @(posedge clock);
    #2 reset = 1'b0;
    repeat (8) @(negedge clock);
    #1;
    check("abort_no_resp", resp_cnt[0], rc);
    check("abort_resp0_product", resp0_product, 0);
    check("abort_resp1_product", resp1_product, 0);
    check("abort_busy", busy, 0);
    rc = resp_cnt[0];
    @(negedge clock);
    #2 push_op(0, 4'd4, 4'd4);
    wait_resp(0, rc, "after_abort");
    check("after_abort_product", last_prod[0], 16);
    wait_idle("after_abort");

    // Exhaustive operand pairs on alternating requesters.
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++) begin
        id = (a * 16 + b) % 2;
        rc = resp_cnt[id];
        @(negedge clock);
        #2 push_op(id, W'(a), W'(b));
        wait_resp(id, rc, $sformatf("exh_%0d_%0d", a, b));
        check($sformatf("exh_%0d_%0d_product", a, b), last_prod[id], a * b);
        check($sformatf("exh_%0d_%0d_latency", a, b), resp_cyc[id] - accept_cyc[id],
              exp_latency(W'(a), W'(b)));
      end
    wait_idle("exhaustive");

    // Random overlapping traffic.
    for (int i = 0; i < 80; i++) begin
      m = 2'($urandom_range(1, 3));
      @(negedge clock);
      #2;
      if (m[0]) begin
        ra = W'($urandom_range(0, 15));
        rb = W'($urandom_range(0, 15));
        push_op(0, ra, rb);
      end
      if (m[1]) begin
        ra = W'($urandom_range(0, 15));
        rb = W'($urandom_range(0, 15));
        push_op(1, ra, rb);
      end
      repeat ($urandom_range(0, 6)) @(negedge clock);
    end
    wait_idle("random");
    repeat (4) @(negedge clock);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 Parameter L_word, default 4: operand width in bits; product width is 2*L_word.
REQ-002 Port clock, input, 1: single clock, all state updates on the rising edge.
REQ-003 Port reset, input, 1: synchronous, active-high reset.
REQ-004 Ports req0_valid and req1_valid, input, 1 each: requester N has an operand pair pending.
REQ-005 Ports req0_ready and req1_ready, output, 1 each: arbiter accepts requester N this cycle.
REQ-006 Ports req0_a, req0_b, req1_a and req1_b, input, L_word each: multiplicand (a) and multiplier (b) per requester.
REQ-007 Ports resp0_valid and resp1_valid, output, 1 each: one-cycle pulse, result for requester N is available.
REQ-008 Ports resp0_product and resp1_product, output, 2*L_word each: result per requester, held until that requester's next response.
REQ-009 Port busy, output, 1: shared multiplier is occupied (state is not IDLE).

Function
REQ-010 The block shall share one shift-add multiplier datapath between two requesters, using FSM states IDLE, MULT and DONE.
REQ-011 Acceptance rules:
  - In IDLE, reqN_ready shall be high only for the requester selected by arbitration.
  - Both ready outputs shall be low in MULT and DONE.
  - Acceptance occurs at edge E0 when reqN_valid and reqN_ready are both high.
REQ-012 Arbitration shall be round-robin:
  - A 1-bit priority pointer selects the winner when both requesters are valid.
  - The sole valid requester wins regardless of the pointer.
  - The pointer shall move to the non-winner at every acceptance.
REQ-013 At E0 the block shall latch a, b and the winner id, zero the accumulator, and enter MULT; operand changes after E0 shall be ignored.
REQ-014 Each edge in MULT shall perform one step:
  - If multiplier[0] is 1, accumulator += multiplicand.
  - multiplier shifts right by 1; multiplicand (2*L_word wide) shifts left by 1.
REQ-015 MULT shall exit to DONE on the edge whose step leaves the multiplier zero, so k = msb_index(b)+1 steps are performed (edges E1..Ek).
REQ-016 At edge E(k+1) the block shall:
  - load the winner's respN_product with the accumulator;
  - pulse respN_valid for one cycle;
  - return to IDLE, so ready may reassert in the same cycle.
REQ-017 Arithmetic shall be unsigned and exact; overflow is impossible at 2*L_word bits.
REQ-018 A request arriving while busy shall wait and must hold valid high; there is no queueing inside the arbiter.
REQ-019 The non-winner's resp outputs shall not change during another requester's operation.

Reset
REQ-020 Reset shall be synchronous and active-high.
REQ-021 On reset the block shall force:
  - state to IDLE;
  - pointer to requester 0;
  - all ready, resp_valid and busy outputs to 0;
  - both resp_product outputs to 0;
  - all datapath registers to 0.
REQ-022 Reset asserted mid-operation shall abort the operation with no response pulse; the first acceptance is possible on the cycle after reset deasserts.

Configuration
REQ-023 The macro MULT_ARB_ZERO_BYPASS_EN shall select zero-operand handling:
  - Defined: if a==0 or b==0, the block skips MULT, goes E0 -> DONE, and delivers product 0 at E1.
  - Undefined: b==0 runs L_word steps, and a==0 with b nonzero runs msb_index(b)+1 steps, producing product 0 after the normal latency.

Structure
REQ-024 A shared package shall hold:
  - the FSM state enum (IDLE, MULT, DONE);
  - the default width constant L_WORD_DEFAULT = 4;
  - the requester-id type.
REQ-025 The shift-add datapath shall be one sub-module, mult_shift_add_dp, containing the multiplicand, multiplier and accumulator registers; its controls are load, step and clear, and it reports multiplier_zero.
REQ-026 Arbitration and the FSM shall reside in mult_arbiter.

Verification
REQ-027 Single request: req0 a=3, b=9, L_word=4 -> resp0_valid pulses at E5 with resp0_product=27; resp1 outputs unchanged.
REQ-028 Simultaneous requests: both valid after reset, req0 a=15 b=15, req1 a=2 b=5 -> req0 granted first (product 225 at E5); req1 accepted on the next IDLE cycle with product 10 after 4 edges; pointer then favours req0.
REQ-029 Fairness: both requesters held valid for 6 operations -> grants alternate 0,1,0,1,0,1.
REQ-030 Zero operand: req1 a=0, b=7 -> with MULT_ARB_ZERO_BYPASS_EN, product 0 at E1; without it, product 0 at E4.
REQ-031 Reset mid-MULT: req0 a=5 b=8, reset asserted at E2 for 1 cycle -> no resp0_valid pulse, all outputs 0; a new request a=4 b=4 then yields 16.
REQ-032 Exhaustive check: all 256 (a,b) pairs on alternating requesters, compared against a*b; latency checked as k+1 edges.
